// File: rtl/wb_slave_pkg.sv
// Shared types and constants for the Wishbone slave memory: FSM states,
// termination kinds, wait-state bounds and the byte-lane merge helper.
package wb_slave_pkg;

  localparam int WAIT_STATES_MIN = 0;
  localparam int WAIT_STATES_MAX = 15;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    KIND_ACK = 2'd0,
    KIND_ERR = 2'd1,
    KIND_RTY = 2'd2
  } resp_kind_e;

  // Replace only the byte lanes of old_w whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_slave_sram.sv
// Word-wide storage with one asynchronous read port and one byte-enabled
// synchronous write port. Contents are deliberately not reset.
module wb_slave_sram
  import wb_slave_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_r [2**AW];

  // Byte-lane write on the rising edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= byte_merge(mem_r[wr_addr], wr_data, wr_be);
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave backed by a word memory, with a fixed number of
// wait states before every termination (ACK, ERR or RTY).
module wb_slave_mem
  import wb_slave_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        LOCK_I,
  input  logic [3:0]  SEL_I,
  input  logic [15:0] TGA_I,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic        RTY_O,
  output logic [15:0] TGD_O,
  input  logic        force_rty
);

  localparam int WS_C = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX :
                        ((WAIT_STATES < WAIT_STATES_MIN) ? WAIT_STATES_MIN : WAIT_STATES);
  localparam logic [CNT_W-1:0] WS_LOAD_C = CNT_W'(WS_C);
  localparam logic [32:0]      SPAN_C    = 33'd4 << DEPTH_LOG2;

  wb_state_e             state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [31:0]           adr_r;
  logic [31:0]           wdata_r;
  logic                  we_r;
  logic [3:0]            sel_r;
  logic [15:0]           tga_r;
  logic                  frty_r;
  logic                  ack_r;
  logic                  err_r;
  logic                  rty_r;
  logic [31:0]           dato_r;
  logic [15:0]           tgd_r;

  logic [31:0]           offset_s;
  logic                  in_range_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  resp_kind_e            kind_s;
  logic                  wr_en_s;
  logic                  abort_s;
  logic [31:0]           rd_data_s;

  // Classify the latched request and derive the memory strobes.
  always_comb begin
    offset_s   = adr_r - BASE_ADDR;
    // Addresses below BASE_ADDR wrap to huge offsets and fail this test too.
    in_range_s = ({1'b0, offset_s} < SPAN_C);
    idx_s      = offset_s[DEPTH_LOG2+1:2];
    kind_s     = KIND_ACK;
    if (frty_r) begin
      kind_s = KIND_RTY;
    end else if ((adr_r[1:0] != 2'b00) || !in_range_s) begin
      kind_s = KIND_ERR;
    end else begin
      kind_s = KIND_ACK;
    end
    wr_en_s = 1'b0;
    if ((state_r == RESP) && (kind_s == KIND_ACK) && we_r) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    abort_s = !(CYC_I && STB_I) && !(LOCK_I && CYC_I && !STB_I);
  end

  // Request FSM with registered terminations, read data and response tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      adr_r   <= 32'h0;
      wdata_r <= 32'h0;
      we_r    <= 1'b0;
      sel_r   <= 4'h0;
      tga_r   <= 16'h0;
      frty_r  <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rty_r   <= 1'b0;
      dato_r  <= 32'h0;
      tgd_r   <= 16'h0;
    end else begin
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
      rty_r  <= 1'b0;
      dato_r <= 32'h0;
      tgd_r  <= 16'h0;
      case (state_r)
        IDLE: begin
          if (CYC_I && STB_I) begin
            adr_r   <= ADR_I;
            wdata_r <= DAT_I;
            we_r    <= WE_I;
            sel_r   <= SEL_I;
            tga_r   <= TGA_I;
            frty_r  <= force_rty;
            if (WS_LOAD_C != {CNT_W{1'b0}}) begin
              state_r <= WAIT;
              cnt_r   <= WS_LOAD_C;
            end else begin
              state_r <= RESP;
              cnt_r   <= '0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (abort_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_W'(1)) begin
            state_r <= RESP;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          state_r <= IDLE;
          tgd_r   <= tga_r;
          case (kind_s)
            KIND_RTY: rty_r <= 1'b1;
            KIND_ERR: err_r <= 1'b1;
            KIND_ACK: begin
              ack_r  <= 1'b1;
              dato_r <= we_r ? 32'h0 : rd_data_s;
            end
            default:  err_r <= 1'b1;
          endcase
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  wb_slave_sram #(
    .AW(DEPTH_LOG2)
  ) u_sram (
    .clk    (clk),
    .wr_en  (wr_en_s),
    .wr_addr(idx_s),
    .wr_data(wdata_r),
    .wr_be  (sel_r),
    .rd_addr(idx_s),
    .rd_data(rd_data_s)
  );

  assign ACK_O = ack_r;
  assign ERR_O = err_r;
  assign RTY_O = rty_r;
  assign DAT_O = dato_r;
  assign TGD_O = tgd_r;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: three instances with different wait states and base
// addresses, directed cases plus random transfers against a behavioural model.
module tb_wb_slave_mem;

  localparam int          WS_OF   [3] = '{1, 3, 0};
  localparam logic [31:0] BASE_OF [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_4000};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_i;
  logic        we, lock, frty, stb;
  logic [3:0]  sel;
  logic [15:0] tga;
  logic [2:0]  cyc;
  logic [31:0] dat_o [3];
  logic        ack_o [3];
  logic        err_o [3];
  logic        rty_o [3];
  logic [15:0] tgd_o [3];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mdl_mem [3][256];
  logic [3:0]  mdl_vld [3][256];
  logic [31:0] last_dat;
  time         last_term_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_slave_mem #(
      .DEPTH_LOG2 (8),
      .BASE_ADDR  (BASE_OF[g]),
      .WAIT_STATES(WS_OF[g])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .ADR_I    (adr),
      .DAT_I    (dat_i),
      .DAT_O    (dat_o[g]),
      .CYC_I    (cyc[g]),
      .STB_I    (stb),
      .WE_I     (we),
      .LOCK_I   (lock),
      .SEL_I    (sel),
      .TGA_I    (tga),
      .ACK_O    (ack_o[g]),
      .ERR_O    (err_o[g]),
      .RTY_O    (rty_o[g]),
      .TGD_O    (tgd_o[g]),
      .force_rty(frty)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input int d, input string tag);
    chk({tag, "_term"}, {29'h0, rty_o[d], err_o[d], ack_o[d]}, 32'h0);
    chk({tag, "_dat"}, dat_o[d], 32'h0);
    chk({tag, "_tgd"}, {16'h0, tgd_o[d]}, 32'h0);
  endtask

  task automatic invalidate_model();
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 256; w++) mdl_vld[d][w] = 4'h0;
    end
  endtask

  // Expected termination {rty,err,ack}, read data and mask of defined bits.
  task automatic model(input int d, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] s, input logic fr,
                       output logic [2:0] ek, output logic [31:0] ed, output logic [31:0] em);
    longint off;
    int     idx;
    off = longint'(a) - longint'(BASE_OF[d]);
    ed  = 32'h0;
    em  = 32'hFFFF_FFFF;
    if (fr) begin
      ek = 3'b100;
    end else if (a[1:0] != 2'b00 || off < 0 || off >= 1024) begin
      ek = 3'b010;
    end else begin
      ek  = 3'b001;
      idx = int'(off / 4);
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) begin
            mdl_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
            mdl_vld[d][idx][b]        = 1'b1;
          end
        end
      end else begin
        ed = mdl_mem[d][idx];
        for (int b = 0; b < 4; b++) em[8*b +: 8] = {8{mdl_vld[d][idx][b]}};
      end
    end
  endtask

  // One transfer; called 1 time unit after a rising edge, returns likewise.
  task automatic do_xfer(input int d, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] s, input logic fr,
                         input logic lk, input int drop_at, input bit keep, input string tag);
    int          ws, n;
    bit          seen, ab;
    logic [2:0]  ek, term;
    logic [31:0] ed, em;
    logic [15:0] t;
    ws = WS_OF[d];
    ab = (drop_at >= 1) && (drop_at <= ws) && !lk;
    t  = 16'($urandom);
    ek = 3'b000; ed = 32'h0; em = 32'h0;
    adr = a; dat_i = w ? wd : 32'($urandom); we = w; sel = s; tga = t;
    frty = fr; lock = lk; cyc = 3'b000; cyc[d] = 1'b1; stb = 1'b1;
    if (!ab) model(d, a, w, wd, s, fr, ek, ed, em);
    seen = 1'b0; n = 0; term = 3'b000;
    while (!seen && n < ws + 5) begin
      @(posedge clk); #1; n++;
      if (n == drop_at) stb = 1'b0;
      term = {rty_o[d], err_o[d], ack_o[d]};
      if (term != 3'b000) seen = 1'b1;
    end
    if (ab) begin
      chk({tag, "_abort_noterm"}, 32'(seen), 32'h0);
      cyc = 3'b000; stb = 1'b0; lock = 1'b0;
      @(posedge clk); #1;
    end else begin
      last_term_t = $time;
      last_dat    = dat_o[d];
      chk({tag, "_latency"}, 32'(n), 32'(ws + 2));
      chk({tag, "_kind"}, {29'h0, term}, {29'h0, ek});
      chk({tag, "_dat"}, dat_o[d] & em, ed & em);
      chk({tag, "_tgd"}, {16'h0, tgd_o[d]}, {16'h0, t});
      if (!keep) begin
        cyc = 3'b000; stb = 1'b0; lock = 1'b0;
        @(posedge clk); #1;
        chk_quiet(d, {tag, "_after"});
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          d, r;
    logic [31:0] a, base;
    logic [31:0] b2b_d [4];
    time         prev_t;
    rst = 1'b1; adr = 32'h0; dat_i = 32'h0; we = 1'b0; lock = 1'b0; frty = 1'b0;
    sel = 4'h0; tga = 16'h0; cyc = 3'b000; stb = 1'b0; prev_t = 0;
    invalidate_model();
    #3 rst = 1'b0;
    #9;
    for (int i = 0; i < 3; i++) chk_quiet(i, "reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Single write then read with one wait state.
    do_xfer(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, -1, 1'b0, "wr_deadbeef");
    do_xfer(0, 32'h10, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, 1'b0, "rd_deadbeef");
    chk("rd_deadbeef_const", last_dat, 32'hDEAD_BEEF);

    // Byte lanes.
    do_xfer(0, 32'h20, 1'b1, 32'h1122_3344, 4'hF, 1'b0, 1'b0, -1, 1'b0, "wr_full");
    do_xfer(0, 32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, -1, 1'b0, "wr_lanes");
    do_xfer(0, 32'h20, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, -1, 1'b0, "wr_sel0");
    do_xfer(0, 32'h20, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, 1'b0, "rd_lanes");
    chk("rd_lanes_const", last_dat, 32'h11BB_33DD);

    // Misaligned and out-of-range reads.
    do_xfer(0, 32'h402, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, 1'b0, "err_misaligned");
    do_xfer(0, 32'h400, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, 1'b0, "err_range");
    do_xfer(1, 32'h0FFC, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, 1'b0, "err_below_base");

    // Retry suppresses the write.
    do_xfer(0, 32'h0, 1'b1, 32'h0000_0077, 4'hF, 1'b0, 1'b0, -1, 1'b0, "wr_prior");
    do_xfer(0, 32'h0, 1'b1, 32'h0000_0005, 4'hF, 1'b1, 1'b0, -1, 1'b0, "wr_retry");
    do_xfer(0, 32'h0, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, 1'b0, "rd_after_retry");
    chk("rd_after_retry_const", last_dat, 32'h0000_0077);

    // Master abort in WAIT, then the same drop held off by LOCK_I.
    do_xfer(1, 32'h1010, 1'b1, 32'hA5A5_A5A5, 4'hF, 1'b0, 1'b0, -1, 1'b0, "wr_before_abort");
    do_xfer(1, 32'h1010, 1'b1, 32'h5A5A_5A5A, 4'hF, 1'b0, 1'b0, 2, 1'b0, "wr_abort");
    do_xfer(1, 32'h1010, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, 1'b0, "rd_after_abort");
    chk("rd_after_abort_const", last_dat, 32'hA5A5_A5A5);
    do_xfer(1, 32'h1014, 1'b1, 32'h0BAD_CAFE, 4'hF, 1'b0, 1'b1, 2, 1'b0, "wr_locked_drop");
    do_xfer(1, 32'h1014, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, 1'b0, "rd_locked_drop");

    // Random transfers, sometimes back-to-back.
    for (int i = 0; i < 60; i++) begin
      d    = $urandom_range(0, 2);
      base = BASE_OF[d];
      r    = $urandom_range(0, 9);
      if (r <= 6)      a = base + 32'(4 * $urandom_range(0, 15));
      else if (r == 7) a = base + 32'(4 * $urandom_range(0, 255));
      else if (r == 8) a = base + 32'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
      else if (base != 32'h0 && $urandom_range(0, 1) == 1) a = base - 32'(4 * $urandom_range(1, 8));
      else             a = base + 32'h400 + 32'(4 * $urandom_range(0, 63));
      do_xfer(d, a, 1'($urandom_range(0, 1)), 32'($urandom), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0), -1,
              (i != 59) && ($urandom_range(0, 1) == 1), "rand");
    end

    // Reset during a termination cycle clears outputs without a clock edge.
    do_xfer(2, 32'h4008, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, -1, 1'b0, "wr_cafe");
    do_xfer(2, 32'h4008, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, 1'b1, "rd_cafe");
    rst = 1'b0; #1;
    chk_quiet(2, "async_rst");
    cyc = 3'b000; stb = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Reset while a write sits in WAIT.
    do_xfer(1, 32'h1020, 1'b1, 32'h1111_1111, 4'hF, 1'b0, 1'b0, -1, 1'b0, "wr_pre_rst");
    adr = 32'h1020; dat_i = 32'h2222_2222; we = 1'b1; sel = 4'hF; frty = 1'b0;
    lock = 1'b0; tga = 16'hBEEF; cyc = 3'b010; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0; #1;
    chk_quiet(1, "rst_in_wait");
    cyc = 3'b000; stb = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    invalidate_model();
    @(posedge clk); #1;
    do_xfer(1, 32'h1020, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, 1'b0, "rd_after_rst");
    chk("rst_write_discarded", 32'(last_dat == 32'h2222_2222), 32'h0);

    // Zero wait states, back-to-back writes then reads.
    for (int i = 0; i < 4; i++) b2b_d[i] = 32'($urandom);
    for (int i = 0; i < 8; i++) begin
      do_xfer(2, 32'h4000 + 32'(4 * (i % 4)), 1'(i < 4), b2b_d[i % 4], 4'hF, 1'b0, 1'b0, -1,
              i != 7, "b2b");
      if (i > 0) chk("b2b_period", 32'(last_term_t - prev_t), 32'd20);
      if (i >= 4) chk("b2b_rd_data", last_dat, b2b_d[i % 4]);
      prev_t = last_term_t;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning memory holds 2**DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15, meaning the number of idle cycles inserted before each response.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports ADR_I (in, 32, byte address), DAT_I (in, 32, write data), DAT_O (out, 32, read data).
REQ-007 SHALL have ports CYC_I, STB_I, WE_I, LOCK_I (in, 1 each), SEL_I (in, 4, byte lanes), TGA_I (in, 16, address tag).
REQ-008 SHALL have ports ACK_O, ERR_O, RTY_O (out, 1 each, termination) and TGD_O (out, 16, response tag).
REQ-009 SHALL have port force_rty, input, 1 bit: test hook that turns the next response into a retry.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-011 SHALL in IDLE, when CYC_I & STB_I are sampled high, latch ADR_I, DAT_I, WE_I, SEL_I, TGA_I, force_rty.
REQ-012 SHALL on that latch go to WAIT when WAIT_STATES>0 and load a counter; go to RESP directly when WAIT_STATES=0.
REQ-013 SHALL decrement the counter in WAIT and go to RESP when it reaches 1.
REQ-014 SHALL assert exactly one of ACK_O/ERR_O/RTY_O for exactly one cycle in RESP, then return to IDLE.
REQ-015 SHALL give fixed latency: request sampled at edge 0, termination high during the cycle after edge WAIT_STATES+1.
REQ-016 SHALL set response priority: RTY (latched force_rty) > ERR (misaligned ADR_I[1:0]!=0, or address outside BASE_ADDR..BASE_ADDR+4*2**DEPTH_LOG2-1) > ACK.
REQ-017 SHALL compute word index as (ADR_I-BASE_ADDR)>>2, truncated to DEPTH_LOG2 bits after the range check.
REQ-018 SHALL commit writes only in the RESP cycle with ACK_O, updating only bytes whose SEL_I bit is 1; SEL_I=0 is a legal no-op write that is ACKed.
REQ-019 SHALL drive DAT_O with the addressed word during a read ACK and 32'h0 at all other times, including write ACK, ERR and RTY.
REQ-020 SHALL drive TGD_O with the latched TGA_I during any termination and 16'h0 otherwise.
REQ-021 SHALL return to IDLE with no write and no termination if CYC_I or STB_I is sampled low in WAIT (master abort).
REQ-022 SHALL sustain back-to-back transfers from a master holding STB_I high, with a period of WAIT_STATES+2 cycles.
REQ-023 SHALL accept LOCK_I without functional effect other than ignoring abort while LOCK_I and CYC_I are high with STB_I low.

Reset
REQ-024 SHALL on rst low immediately force IDLE, counter 0, and ACK_O=ERR_O=RTY_O=0, DAT_O=0, TGD_O=0.
REQ-025 SHALL leave memory contents undefined after reset, and SHALL discard any in-flight write when reset hits mid-transfer.
REQ-026 SHALL sample the first request no earlier than the first rising edge after rst deasserts.

Structure
REQ-027 SHALL place the state enum, the response-kind enum and WAIT_STATES bounds in package wb_slave_pkg.
REQ-028 SHALL isolate storage in sub-module wb_slave_sram: one read port, one write port, 4-bit byte enable, 1 clock.

Verification
REQ-029 SHALL check this write/read case: WAIT_STATES=1, write 32'hDEAD_BEEF to 0x10 with SEL=4'hF, then read 0x10 -> ACK two cycles after each request, DAT_O=32'hDEAD_BEEF, TGD_O echoes TGA.
REQ-030 SHALL check byte lanes: write 32'h1122_3344 SEL=4'hF, then 32'hAABB_CCDD SEL=4'b0101 to 0x20, then read -> 32'h11BB_33DD.
REQ-031 SHALL check errors: a read of 0x402 (misaligned) and a read of BASE_ADDR+0x400 (out of range, DEPTH_LOG2=8) -> ERR_O one cycle each, DAT_O=0, no ACK.
REQ-032 SHALL check retry: force_rty=1 on a write of 32'h5 to 0x0 -> RTY_O; a following read of 0x0 returns the prior value, not 5.
REQ-033 SHALL check abort: WAIT_STATES=3, STB_I dropped after 1 wait cycle on a write -> no termination, memory unchanged, next request served normally.
REQ-034 SHALL check reset mid-transfer: rst low during WAIT -> all outputs 0 asynchronously, FSM IDLE; WAIT_STATES=0 back-to-back reads terminate every 2 cycles.
